// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan decoder.
//   NUM_DIGITS / AN_W : number of multiplexed digits (one anode each)
//   SEG_W / BCD_W     : cathode width and BCD nibble width
//   SEG_0..SEG_9      : legal active-high {g,f,e,d,c,b,a} patterns
//   sel_kind_e        : classification of the anode select lines
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int AN_W       = NUM_DIGITS;
    localparam int SEG_W      = 7;
    localparam int BCD_W      = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    typedef enum logic [1:0] {
        SEL_BLANK = 2'd0,   // no anode low
        SEL_ONE   = 2'd1,   // exactly one anode low
        SEL_MULTI = 2'd2    // two or more anodes low
    } sel_kind_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational decode of an active-low cathode pattern.
//   ca    in  7  active-low cathodes {g,f,e,d,c,b,a}
//   bcd   out 4  decoded digit (0 when illegal)
//   legal out 1  pattern is exactly one of the digits 0..9
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] ca,
    output logic [BCD_W-1:0] bcd,
    output logic             legal
);

    logic [SEG_W-1:0] seg;

    assign seg = ~ca;

    always_comb begin
        bcd   = '0;
        legal = 1'b1;
        unique case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the four BCD digits from a multiplexed,
// active-low seven-segment scan, with glitch filtering and health flags.
//   clock, reset       rising-edge clock, async active-high reset
//   an[3:0]            active-low anodes, an[i]=0 selects digit i
//   ca[6:0]            active-low cathodes {g,f,e,d,c,b,a}
//   digits[15:0]       {d3,d2,d1,d0} BCD
//   digit_valid[3:0]   digit i holds a legally decoded value
//   frame_done         pulse when all four digits captured since last pulse
//   bad_pattern        pulse on capture of a non-digit pattern
//   bad_select         pulse on capture with more than one anode low
//   alive              a legal capture happened within TIMEOUT_CYCLES
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [AN_W-1:0]             an,
    input  logic [SEG_W-1:0]            ca,
    output logic [NUM_DIGITS*BCD_W-1:0] digits,
    output logic [NUM_DIGITS-1:0]       digit_valid,
    output logic                        frame_done,
    output logic                        bad_pattern,
    output logic                        bad_select,
    output logic                        alive
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SMP_W = AN_W + SEG_W;

    logic [SMP_W-1:0]      smp;
    logic [SMP_W-1:0]      cur;
    logic                  same;
    logic [CNT_W-1:0]      cnt;
    logic                  capture;
    logic [AN_W-1:0]       sel_an;
    logic [SEG_W-1:0]      sel_ca;
    sel_kind_e             kind;
    logic [IDX_W-1:0]      idx;
    logic [BCD_W-1:0]      dec_bcd;
    logic                  dec_legal;
    logic                  legal_cap;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_nxt;
    logic [TO_W-1:0]       tcnt;

    assign cur     = {an, ca};
    assign same    = (cur == smp);
    // Fires exactly once per stable window: only on the edge where the
    // saturating count steps into SETTLE_CYCLES.
    assign capture = same && (cnt == CNT_W'(SETTLE_CYCLES - 1));

    // Decode from the registered sample, which equals the live input on a
    // capture edge, so outputs never depend combinationally on an/ca.
    assign sel_an = smp[SMP_W-1:SEG_W];
    assign sel_ca = smp[SEG_W-1:0];

    seg7_to_bcd u_dec (
        .ca    (sel_ca),
        .bcd   (dec_bcd),
        .legal (dec_legal)
    );

    always_comb begin
        int n_low;
        n_low = 0;
        idx   = '0;
        kind  = SEL_MULTI;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_an[i]) begin
                n_low = n_low + 1;
                idx   = IDX_W'(i);
            end
        end
        if (n_low == 0)
            kind = SEL_BLANK;
        else if (n_low == 1)
            kind = SEL_ONE;
    end

    assign legal_cap = capture && (kind == SEL_ONE) && dec_legal;

    always_comb begin
        seen_nxt      = seen;
        seen_nxt[idx] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // All-ones sample is a blank select, so a quiet bus after reset
            // settles harmlessly.
            smp         <= '1;
            cnt         <= '0;
            digits      <= '0;
            digit_valid <= '0;
            seen        <= '0;
            tcnt        <= '0;
            alive       <= 1'b0;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            bad_select  <= 1'b0;
        end else begin
            smp         <= cur;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            bad_select  <= 1'b0;

            if (!same)
                cnt <= '0;
            else if (cnt != CNT_W'(SETTLE_CYCLES))
                cnt <= cnt + 1'b1;

            if (legal_cap) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (idx == IDX_W'(i))
                        digits[i*BCD_W +: BCD_W] <= dec_bcd;
                digit_valid[idx] <= 1'b1;
                tcnt             <= '0;
                alive            <= 1'b1;
                if (&seen_nxt) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_nxt;
                end
            end else begin
                // Legal capture takes priority over the timeout, so the
                // timeout only runs in this branch.
                if (tcnt != TO_W'(TIMEOUT_CYCLES)) begin
                    tcnt <= tcnt + 1'b1;
                    if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        digit_valid <= '0;
                        seen        <= '0;
                        alive       <= 1'b0;
                    end
                end
                if (capture && kind == SEL_ONE) begin
                    bad_pattern      <= 1'b1;
                    digit_valid[idx] <= 1'b0;
                end
                if (capture && kind == SEL_MULTI)
                    bad_select <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder (SETTLE_CYCLES=4, TIMEOUT_CYCLES=100):
// table of scan vectors with expected end state and pulse counts, plus
// hand sequences for timeout and mid-settle reset.
module tb_seg_scan_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  an    = 4'hF;
    logic [6:0]  ca    = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done, bad_pattern, bad_select, alive;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clock       (clock),
        .reset       (reset),
        .an          (an),
        .ca          (ca),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .bad_pattern (bad_pattern),
        .bad_select  (bad_select),
        .alive       (alive)
    );

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  ca;
        int          hold;
        logic [15:0] digits;
        logic [3:0]  dv;
        int          fd;
        int          bp;
        int          bs;
        logic        alive;
    } vec_t;

    vec_t tbl[12];
    vec_t exp_q[$];

    function automatic vec_t mk(logic [3:0] a, logic [6:0] c, int h,
                                logic [15:0] d, logic [3:0] v,
                                int f, int p, int s, logic al);
        vec_t r;
        r.an = a; r.ca = c; r.hold = h; r.digits = d; r.dv = v;
        r.fd = f; r.bp = p; r.bs = s; r.alive = al;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one vector for 'hold' edges, counting pulses seen after each edge,
    // then compare against the expectation queued at drive time.
    task automatic run_vec(input vec_t v, input int row);
        int   fd, bp, bs;
        vec_t e;
        fd = 0; bp = 0; bs = 0;
        an = v.an;
        ca = v.ca;
        exp_q.push_back(v);
        for (int k = 0; k < v.hold; k++) begin
            @(posedge clock);
            #1;
            if (frame_done)  fd++;
            if (bad_pattern) bp++;
            if (bad_select)  bs++;
        end
        e = exp_q.pop_front();
        chk($sformatf("row%0d digits", row), 32'(digits), 32'(e.digits));
        chk($sformatf("row%0d digit_valid", row), 32'(digit_valid), 32'(e.dv));
        chk($sformatf("row%0d frame_done_count", row), fd, e.fd);
        chk($sformatf("row%0d bad_pattern_count", row), bp, e.bp);
        chk($sformatf("row%0d bad_select_count", row), bs, e.bs);
        chk($sformatf("row%0d alive", row), 32'(alive), 32'(e.alive));
    endtask

    initial begin
        bit got;

        // Reset state (async, before any clock edge).
        #2;
        chk("reset digits", 32'(digits), 0);
        chk("reset digit_valid", 32'(digit_valid), 0);
        chk("reset frame_done", 32'(frame_done), 0);
        chk("reset bad_pattern", 32'(bad_pattern), 0);
        chk("reset bad_select", 32'(bad_select), 0);
        chk("reset alive", 32'(alive), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        //            an       ca        hold digits    dv    fd bp bs alive
        tbl[0]  = mk(4'b0111, ~7'h06, 10, 16'h1000, 4'h8, 0, 0, 0, 1'b1);
        tbl[1]  = mk(4'b1011, ~7'h5B, 10, 16'h1200, 4'hC, 0, 0, 0, 1'b1);
        tbl[2]  = mk(4'b1101, ~7'h4F, 10, 16'h1230, 4'hE, 0, 0, 0, 1'b1);
        tbl[3]  = mk(4'b1110, ~7'h66, 10, 16'h1234, 4'hF, 1, 0, 0, 1'b1);
        tbl[4]  = mk(4'b1110, ~7'h06,  4, 16'h1234, 4'hF, 0, 0, 0, 1'b1); // too short
        tbl[5]  = mk(4'b1111,  7'h7F,  3, 16'h1234, 4'hF, 0, 0, 0, 1'b1);
        tbl[6]  = mk(4'b1110, ~7'h06,  5, 16'h1231, 4'hF, 0, 0, 0, 1'b1); // just long enough
        tbl[7]  = mk(4'b1101,  7'h7F, 10, 16'h1231, 4'hD, 0, 1, 0, 1'b1); // all segments off
        tbl[8]  = mk(4'b1100, ~7'h06, 10, 16'h1231, 4'hD, 0, 0, 1, 1'b1); // two anodes
        tbl[9]  = mk(4'b1111,  7'h7F,  3, 16'h1231, 4'hD, 0, 0, 0, 1'b1);
        tbl[10] = mk(4'b0111, ~7'h66, 10, 16'h4231, 4'hD, 0, 0, 0, 1'b1);
        tbl[11] = mk(4'b1011, ~7'h6D, 10, 16'h4531, 4'hD, 0, 0, 0, 1'b1);

        for (int r = 0; r < 12; r++)
            run_vec(tbl[r], r);

        // Complete the frame on d1, then go blank and watch the timeout.
        an = 4'b1101;
        ca = ~7'h7D;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clock);
            #1;
            if (frame_done) got = 1'b1;
        end
        chk("frame pulse seen", 32'(got), 1);
        chk("frame digits", 32'(digits), 32'h4561);
        chk("frame digit_valid", 32'(digit_valid), 4'hF);
        an = 4'hF;
        ca = 7'h7F;
        repeat (99) @(posedge clock);
        #1;
        chk("pre-timeout alive", 32'(alive), 1);
        chk("pre-timeout digit_valid", 32'(digit_valid), 4'hF);
        @(posedge clock);
        #1;
        chk("timeout alive", 32'(alive), 0);
        chk("timeout digit_valid", 32'(digit_valid), 0);
        chk("timeout digits kept", 32'(digits), 32'h4561);
        repeat (20) @(posedge clock);
        #1;
        chk("post-timeout alive", 32'(alive), 0);
        chk("post-timeout digits", 32'(digits), 32'h4561);

        // Reset while the settle count sits at 2.
        an = 4'b1110;
        ca = ~7'h5B;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("mid-settle reset digits", 32'(digits), 0);
        chk("mid-settle reset digit_valid", 32'(digit_valid), 0);
        chk("mid-settle reset alive", 32'(alive), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("post-reset 4 edges digit_valid", 32'(digit_valid), 0);
        @(posedge clock);
        #1;
        chk("post-reset capture digits", 32'(digits), 32'h0002);
        chk("post-reset capture digit_valid", 32'(digit_valid), 4'h1);
        chk("post-reset capture alive", 32'(alive), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
